// File: rtl/nmea_field_extractor_pkg.sv
// ---------------------------------------------------------------------------
// nmea_pkg
// Shared definitions for the NMEA-0183 field extractor:
//   - parser state encoding (enum for debug visibility, plain constants for
//     the FSM register itself)
//   - ASCII framing constants
//   - hex_nibble(): ASCII hex digit to {valid, nibble}
// ---------------------------------------------------------------------------
package nmea_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_FIELDS = 3'd2,
        S_CHK_HI = 3'd3,
        S_CHK_LO = 3'd4
    } nmea_state_e;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HDR    = 3'd1;
    localparam logic [2:0] ST_FIELDS = 3'd2;
    localparam logic [2:0] ST_CHK_HI = 3'd3;
    localparam logic [2:0] ST_CHK_LO = 3'd4;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;

    // Returns {valid, value}. Digits '0'-'9' carry their value in the low
    // nibble; 'A'-'F' / 'a'-'f' have low nibble 1..6, so value = low + 9.
    function automatic logic [4:0] hex_nibble(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) begin
            return {1'b1, c[3:0]};
        end
        if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            return {1'b1, c[3:0] + 4'd9};
        end
        return 5'b0_0000;
    endfunction

endpackage

// File: rtl/nmea_field_extractor_if.sv
// ---------------------------------------------------------------------------
// nmea_field_extractor_if
// Byte stream from the UART receiver into the sentence parser.
//   rx_data   8  received byte
//   rx_valid  1  byte strobe
// Handshake: valid-only strobe. A byte is transferred on every clock edge
// where rx_valid is 1; there is no ready, the consumer accepts one byte per
// cycle unconditionally and never applies backpressure.
// ---------------------------------------------------------------------------
interface nmea_field_extractor_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/nmea_field_slot.sv
// ---------------------------------------------------------------------------
// nmea_field_slot
// One capture slot: shadow buffer + length + overflow flag filled while a
// sentence is parsed, and a committed copy updated only on commit.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   clear               start of sentence: shadow to PAD, length/ovf to 0
//   wr_en, wr_byte      append one character to the shadow buffer
//   commit              copy shadow state to the outputs
//   data_out            committed bytes, byte j at [j*8 +: 8]
//   len_out             committed length (saturates at FIELD_LEN)
//   ovf_out             committed overflow flag
// ---------------------------------------------------------------------------
module nmea_field_slot #(
    parameter int         FIELD_LEN = 8,
    parameter logic [7:0] PAD       = 8'h30
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [7:0]             wr_byte,
    input  logic                   commit,
    output logic [FIELD_LEN*8-1:0] data_out,
    output logic [3:0]             len_out,
    output logic                   ovf_out
);

    localparam logic [3:0] LEN_MAX = 4'(FIELD_LEN);

    logic [FIELD_LEN*8-1:0] shadow;
    logic [3:0]             shadow_len;
    logic                   shadow_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= {FIELD_LEN{PAD}};
            shadow_len <= 4'd0;
            shadow_ovf <= 1'b0;
        end else if (clear) begin
            shadow     <= {FIELD_LEN{PAD}};
            shadow_len <= 4'd0;
            shadow_ovf <= 1'b0;
        end else if (wr_en) begin
            if (shadow_len < LEN_MAX) begin
                // Loop-compare instead of a variable index keeps the
                // 4-bit length from having to match the slot index width.
                for (int j = 0; j < FIELD_LEN; j++) begin
                    if (shadow_len == 4'(j)) begin
                        shadow[j*8 +: 8] <= wr_byte;
                    end
                end
                shadow_len <= shadow_len + 4'd1;
            end else begin
                shadow_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= {FIELD_LEN{PAD}};
            len_out  <= 4'd0;
            ovf_out  <= 1'b0;
        end else if (commit) begin
            data_out <= shadow;
            len_out  <= shadow_len;
            ovf_out  <= shadow_ovf;
        end
    end

endmodule

// File: rtl/nmea_field_extractor.sv
// ---------------------------------------------------------------------------
// nmea_field_extractor
// NMEA-0183 sentence parser: matches a 5-character header after '$',
// captures selected comma-delimited fields into fixed-length slots and
// commits them atomically only when the '*hh' XOR checksum matches.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   rx              byte stream (slave modport: rx_data, rx_valid)
//   fields_out      committed slots, byte j of slot i at [(i*FIELD_LEN+j)*8 +: 8]
//   field_len_out   committed character count per slot (4 bits each)
//   field_ovf       committed per-slot overflow flag
//   frame_valid     one-cycle pulse after a checksum-good commit
//   chk_err         one-cycle pulse on bad checksum or non-hex digit
//   state_dbg       current parser state
// ---------------------------------------------------------------------------
module nmea_field_extractor
    import nmea_pkg::*;
#(
    parameter logic [39:0]             HEADER     = "GPRMC",
    parameter int                      NUM_FIELDS = 4,
    parameter int                      FIELD_LEN  = 8,
    parameter logic [NUM_FIELDS*4-1:0] FIELD_IDX  = {4'd7, 4'd5, 4'd3, 4'd2},
    parameter logic [7:0]              PAD        = "0"
) (
    input  logic                              clk,
    input  logic                              rst_n,
    nmea_field_extractor_if.slave             rx,
    output logic [NUM_FIELDS*FIELD_LEN*8-1:0] fields_out,
    output logic [NUM_FIELDS*4-1:0]           field_len_out,
    output logic [NUM_FIELDS-1:0]             field_ovf,
    output logic                              frame_valid,
    output logic                              chk_err,
    output nmea_state_e                       state_dbg
);

    logic [2:0] state;
    logic [2:0] hdr_idx;
    logic [3:0] field_cnt;
    logic [7:0] csum;
    logic [3:0] chk_hi;

    logic [7:0] rx_byte;
    logic       byte_dollar;
    logic       byte_comma;
    logic       byte_star;
    logic       byte_ctrl;
    logic       byte_text;
    logic [4:0] hex;
    logic [7:0] hdr_byte;
    logic       sentence_start;
    logic       commit;

    assign rx_byte     = rx.rx_data;
    assign byte_dollar = (rx_byte == ASCII_DOLLAR);
    assign byte_comma  = (rx_byte == ASCII_COMMA);
    assign byte_star   = (rx_byte == ASCII_STAR);
    // CR and LF are both below 0x20, so one range test covers all terminators.
    assign byte_ctrl   = (rx_byte < 8'h20);
    assign byte_text   = !byte_dollar && !byte_comma && !byte_star && !byte_ctrl;
    assign hex         = hex_nibble(rx_byte);

    // Header characters are stored MSB-first: index 0 is HEADER[39:32].
    always_comb begin
        hdr_byte = 8'h00;
        for (int k = 0; k < 5; k++) begin
            if (hdr_idx == 3'(k)) begin
                hdr_byte = HEADER[(4-k)*8 +: 8];
            end
        end
    end

    assign sentence_start = rx.rx_valid && byte_dollar;
    // '$' has priority in every state, so a '$' in CHK_LO never commits.
    assign commit = rx.rx_valid && (state == ST_CHK_LO) && !byte_dollar
                    && hex[4] && ({chk_hi, hex[3:0]} == csum);

    assign state_dbg = nmea_state_e'(state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            hdr_idx     <= 3'd0;
            field_cnt   <= 4'd0;
            csum        <= 8'h00;
            chk_hi      <= 4'd0;
            frame_valid <= 1'b0;
            chk_err     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            chk_err     <= 1'b0;
            if (rx.rx_valid) begin
                if (byte_dollar) begin
                    state     <= ST_HDR;
                    hdr_idx   <= 3'd0;
                    field_cnt <= 4'd0;
                    csum      <= 8'h00;
                end else begin
                    case (state)
                        ST_HDR: begin
                            if (hdr_idx == 3'd5) begin
                                if (byte_comma) begin
                                    state     <= ST_FIELDS;
                                    field_cnt <= 4'd1;
                                    csum      <= csum ^ rx_byte;
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end else if (rx_byte == hdr_byte) begin
                                hdr_idx <= hdr_idx + 3'd1;
                                csum    <= csum ^ rx_byte;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                        ST_FIELDS: begin
                            if (byte_comma) begin
                                if (field_cnt != 4'd15) begin
                                    field_cnt <= field_cnt + 4'd1;
                                end
                                csum <= csum ^ rx_byte;
                            end else if (byte_star) begin
                                state <= ST_CHK_HI;
                            end else if (byte_ctrl) begin
                                state <= ST_IDLE;
                            end else begin
                                csum <= csum ^ rx_byte;
                            end
                        end
                        ST_CHK_HI: begin
                            if (hex[4]) begin
                                chk_hi <= hex[3:0];
                                state  <= ST_CHK_LO;
                            end else begin
                                chk_err <= 1'b1;
                                state   <= ST_IDLE;
                            end
                        end
                        ST_CHK_LO: begin
                            if (commit) begin
                                frame_valid <= 1'b1;
                            end else begin
                                chk_err <= 1'b1;
                            end
                            state <= ST_IDLE;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < NUM_FIELDS; i++) begin : g_slot
            logic wr_en;
            assign wr_en = rx.rx_valid && (state == ST_FIELDS) && byte_text
                           && (field_cnt == FIELD_IDX[i*4 +: 4]);

            nmea_field_slot #(
                .FIELD_LEN (FIELD_LEN),
                .PAD       (PAD)
            ) u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .clear    (sentence_start),
                .wr_en    (wr_en),
                .wr_byte  (rx_byte),
                .commit   (commit),
                .data_out (fields_out[i*FIELD_LEN*8 +: FIELD_LEN*8]),
                .len_out  (field_len_out[i*4 +: 4]),
                .ovf_out  (field_ovf[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_nmea_field_extractor.sv
module tb_nmea_field_extractor;
    import nmea_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nmea_field_extractor_if rx_bus ();

    logic [255:0] fields_a, fields_b;
    logic [15:0]  len_a, len_b;
    logic [3:0]   ovf_a, ovf_b;
    logic         fv_a, ce_a, fv_b, ce_b;
    nmea_state_e  st_a, st_b;

    nmea_field_extractor dut_a (
        .clk (clk), .rst_n (rst_n), .rx (rx_bus),
        .fields_out (fields_a), .field_len_out (len_a), .field_ovf (ovf_a),
        .frame_valid (fv_a), .chk_err (ce_a), .state_dbg (st_a)
    );

    nmea_field_extractor #(.FIELD_IDX ({4'd7, 4'd7, 4'd2, 4'd2})) dut_b (
        .clk (clk), .rst_n (rst_n), .rx (rx_bus),
        .fields_out (fields_b), .field_len_out (len_b), .field_ovf (ovf_b),
        .frame_valid (fv_b), .chk_err (ce_b), .state_dbg (st_b)
    );

    // ---------------- pulse monitors ----------------
    int n_assert = 0;
    int n_fail   = 0;
    int fv_cnt_a = 0, ce_cnt_a = 0, fv_cnt_b = 0, ce_cnt_b = 0, both_cnt = 0;
    int fv0, ce0, fvb0;

    always @(negedge clk) begin
        if (fv_a) fv_cnt_a++;
        if (ce_a) ce_cnt_a++;
        if (fv_b) fv_cnt_b++;
        if (ce_b) ce_cnt_b++;
        if ((fv_a && ce_a) || (fv_b && ce_b)) both_cnt++;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Text is written left to right; slot byte 0 is the least significant byte.
    function automatic logic [63:0] pack8(input string s);
        logic [63:0] v;
        v = '0;
        for (int j = 0; j < 8; j++) v[j*8 +: 8] = s[j];
        return v;
    endfunction

    task automatic check_slot(input string tag, input logic [255:0] f, input logic [15:0] l,
                              input int idx, input string txt, input int len);
        check({tag, "_data"}, f[idx*64 +: 64], pack8(txt));
        check({tag, "_len"}, 64'(l[idx*4 +: 4]), 64'(len));
    endtask

    task automatic send_str(input string s, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            rx_bus.rx_data  = s[i];
            rx_bus.rx_valid = 1'b1;
            @(negedge clk);
            if (gaps) begin
                rx_bus.rx_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        rx_bus.rx_valid = 1'b0;
    endtask

    task automatic send_crlf();
        rx_bus.rx_valid = 1'b1;
        rx_bus.rx_data  = 8'h0D;
        @(negedge clk);
        rx_bus.rx_data  = 8'h0A;
        @(negedge clk);
        rx_bus.rx_valid = 1'b0;
    endtask

    task automatic mark();
        fv0  = fv_cnt_a;
        ce0  = ce_cnt_a;
        fvb0 = fv_cnt_b;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    string rmc   = "$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A";
    string rmc_b = "$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6B";
    string rmc_l = "$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6a";
    string short_ok = "$GPRMC,,B,12,,7,,X*49";

    // ---------------- directed sequence ----------------
    initial begin
        rst_n           = 1'b0;
        rx_bus.rx_data  = 8'h00;
        rx_bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_slot0", fields_a[63:0], pack8("00000000"));
        check("rst_slot3", fields_a[255:192], pack8("00000000"));
        check("rst_len", 64'(len_a), 64'd0);
        check("rst_ovf", 64'(ovf_a), 64'd0);
        check("rst_fv", 64'(fv_a), 64'd0);
        check("rst_ce", 64'(ce_a), 64'd0);
        check("rst_state", 64'(st_a), 64'(S_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // Reference sentence, irregular byte spacing
        mark();
        send_str(rmc, 1'b1);
        send_crlf();
        settle();
        check("s1_fv", 64'(fv_cnt_a - fv0), 64'd1);
        check("s1_ce", 64'(ce_cnt_a - ce0), 64'd0);
        check_slot("s1_slot0", fields_a, len_a, 0, "A0000000", 1);
        check_slot("s1_slot1", fields_a, len_a, 1, "4807.038", 8);
        check_slot("s1_slot2", fields_a, len_a, 2, "01131.00", 8);
        check_slot("s1_slot3", fields_a, len_a, 3, "022.4000", 5);
        check("s1_ovf", 64'(ovf_a), 64'b0100);
        check("s1_state", 64'(st_a), 64'(S_IDLE));

        // Wrong checksum: error pulse, outputs held
        mark();
        send_str(rmc_b, 1'b0);
        send_crlf();
        settle();
        check("bad_ce", 64'(ce_cnt_a - ce0), 64'd1);
        check("bad_fv", 64'(fv_cnt_a - fv0), 64'd0);
        check_slot("bad_slot1", fields_a, len_a, 1, "4807.038", 8);
        check("bad_ovf", 64'(ovf_a), 64'b0100);

        // Non-hex checksum digit
        mark();
        send_str("$GPRMC,1*Z", 1'b0);
        settle();
        check("nonhex_ce", 64'(ce_cnt_a - ce0), 64'd1);
        check("nonhex_fv", 64'(fv_cnt_a - fv0), 64'd0);

        // Other sentence type with a correct checksum: ignored
        mark();
        send_str("$GPGGA,1*4B", 1'b0);
        send_crlf();
        settle();
        check("gga_fv", 64'(fv_cnt_a - fv0), 64'd0);
        check("gga_ce", 64'(ce_cnt_a - ce0), 64'd0);
        check_slot("gga_slot0", fields_a, len_a, 0, "A0000000", 1);

        // Truncated sentence then a valid one: only the second commits
        mark();
        send_str("$GPRMC,1,Z,5555", 1'b0);
        rx_bus.rx_valid = 1'b1;
        rx_bus.rx_data  = 8'h0A;
        @(negedge clk);
        rx_bus.rx_valid = 1'b0;
        settle();
        check("trunc_fv", 64'(fv_cnt_a - fv0), 64'd0);
        check_slot("trunc_slot0", fields_a, len_a, 0, "A0000000", 1);
        send_str(short_ok, 1'b0);
        send_crlf();
        settle();
        check("s2_fv", 64'(fv_cnt_a - fv0), 64'd1);
        check("s2_ce", 64'(ce_cnt_a - ce0), 64'd0);
        check_slot("s2_slot0", fields_a, len_a, 0, "B0000000", 1);
        check_slot("s2_slot1", fields_a, len_a, 1, "12000000", 2);
        check_slot("s2_slot2", fields_a, len_a, 2, "70000000", 1);
        check_slot("s2_slot3", fields_a, len_a, 3, "X0000000", 1);
        check("s2_ovf", 64'(ovf_a), 64'd0);

        // Asynchronous reset in the middle of a field
        send_str("$GPRMC,1,A,48", 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_slot("mid_rst_slot0", fields_a, len_a, 0, "00000000", 0);
        check_slot("mid_rst_slot1", fields_a, len_a, 1, "00000000", 0);
        check("mid_rst_state", 64'(st_a), 64'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mark();
        send_str(rmc, 1'b0);
        send_crlf();
        settle();
        check("post_rst_fv", 64'(fv_cnt_a - fv0), 64'd1);
        check_slot("post_rst_slot1", fields_a, len_a, 1, "4807.038", 8);
        check_slot("post_rst_slot2", fields_a, len_a, 2, "01131.00", 8);

        // '$' in place of the low checksum digit aborts and restarts
        mark();
        send_str("$GPRMC,,B,12,,7,,X*4", 1'b0);
        send_str(short_ok, 1'b0);
        settle();
        check("abort_fv", 64'(fv_cnt_a - fv0), 64'd1);
        check("abort_ce", 64'(ce_cnt_a - ce0), 64'd0);
        check_slot("abort_slot1", fields_a, len_a, 1, "12000000", 2);

        // Lowercase checksum; second instance has duplicate field numbers
        mark();
        send_str(rmc_l, 1'b0);
        send_crlf();
        settle();
        check("lc_fv", 64'(fv_cnt_a - fv0), 64'd1);
        check_slot("lc_a_slot1", fields_a, len_a, 1, "4807.038", 8);
        check("dup_fv", 64'(fv_cnt_b - fvb0), 64'd1);
        check_slot("dup_slot0", fields_b, len_b, 0, "A0000000", 1);
        check_slot("dup_slot1", fields_b, len_b, 1, "A0000000", 1);
        check_slot("dup_slot2", fields_b, len_b, 2, "022.4000", 5);
        check_slot("dup_slot3", fields_b, len_b, 3, "022.4000", 5);
        check("dup_ovf", 64'(ovf_b), 64'd0);

        check("pulses_exclusive", 64'(both_cnt), 64'd0);
        check("b_ce_total", 64'(ce_cnt_b), 64'(ce_cnt_a));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nmea_field_extractor.md
# nmea_field_extractor

Parametrised NMEA-0183 sentence parser that sits directly behind the UART receiver and replaces the fixed-format GPRMC parser. It matches a configurable five-character sentence header and captures up to NUM_FIELDS configurable comma-delimited fields into fixed-length ASCII slots. It verifies the `*hh` XOR checksum and commits all captured fields atomically to the outputs only when the checksum matches, so downstream display and speed logic never sees a torn or corrupted sentence.

## Interface
- HEADER, "GPRMC", 40-bit ASCII sentence ID (talker and type) to match after `$`.
- NUM_FIELDS, 4, number of capture slots (1..8).
- FIELD_LEN, 8, bytes per slot (1..15).
- FIELD_IDX, {4'd7,4'd5,4'd3,4'd2}, packed 4-bit field numbers; slot i uses bits [4i+3:4i]. Field n is the text after the n-th comma. Legal values are 1..15.
- PAD, "0", fill byte for unwritten slot positions.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rx_data  in  8  received byte.
- rx_valid  in  1  byte strobe, one cycle per byte.
- fields_out  out  NUM_FIELDS*FIELD_LEN*8  committed slots. Byte j of slot i is at [(i*FIELD_LEN+j)*8 +: 8].
- field_len_out  out  NUM_FIELDS*4  committed character count per slot, saturating at FIELD_LEN.
- field_ovf  out  NUM_FIELDS  committed per-slot overflow flag (field longer than FIELD_LEN).
- frame_valid  out  1  one-cycle pulse after a checksum-good commit.
- chk_err  out  1  one-cycle pulse on checksum mismatch or malformed checksum digits.

## Operation
- States: IDLE, HDR, FIELDS, CHK_HI, CHK_LO. Only cycles with rx_valid=1 advance the FSM.
- `$` in any state: clear the shadow slots to PAD, clear lengths and overflow flags, set field counter to 0, set checksum accumulator to 0, and go to HDR with header index 0.
- HDR: compare the byte against HEADER byte [index], MSB-first. A mismatch goes to IDLE. After 5 matches, the next byte must be `,`, which goes to FIELDS with field counter 1; any other byte goes to IDLE.
- Checksum accumulator: XOR of every byte strictly between `$` and `*`.
- FIELDS, on `,`: field counter increments, saturating at 15.
- FIELDS, on `*`: go to CHK_HI.
- FIELDS, on CR, LF or any byte < 0x20: go to IDLE with no commit and no pulse.
- FIELDS, on any other byte: every slot whose FIELD_IDX equals the field counter writes the byte at its length position and increments its length if length < FIELD_LEN. Otherwise the byte is dropped and the slot's overflow bit is set.
- Duplicate FIELD_IDX values are legal; each matching slot captures independently.
- CHK_HI and CHK_LO accept 0-9, A-F and a-f. A non-hex byte pulses chk_err and goes to IDLE.
- On the CHK_LO digit:
  - Match: copy shadow slots, lengths and overflow flags to the outputs, pulse frame_valid, go to IDLE.
  - Mismatch: pulse chk_err, outputs unchanged, go to IDLE.
- Outputs hold their last committed values indefinitely. A field absent from the sentence commits as all PAD with length 0.

## Timing
- Reset values: fields_out is all PAD, field_len_out 0, field_ovf 0, frame_valid 0, chk_err 0, FSM IDLE.
- Reset is asynchronous assert and synchronous deassert at the block's flop level. Reset mid-sentence discards the sentence.
- Commit latency: outputs and the pulse register on the edge that samples the final checksum digit; they are visible the following cycle.
- frame_valid and chk_err are high for exactly one clk cycle, independent of rx_valid spacing. They are never high together.
- Back-to-back bytes (rx_valid high on every cycle) are supported with no stall.
- `$` arriving in CHK_LO restarts parsing and aborts the pending commit.

## Structure
- The shared package nmea_pkg holds:
  - the state enum;
  - ASCII constants (`$`, `,`, `*`, CR, LF);
  - the hex-digit-to-nibble function with a valid flag.
- Sub-module nmea_field_slot holds one shadow buffer, length counter, overflow bit and committed copy. It is instantiated NUM_FIELDS times through generate, with FIELD_LEN and PAD passed down.

## Test plan
- Defaults, sentence `$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A` + CRLF:
  - frame_valid pulses once.
  - Slot0 is "A0000000", length 1.
  - Slot1 is "4807.038", length 8.
  - Slot2 is "01131.00", length 8, ovf=1.
  - Slot3 is "022.4000", length 5.
- Same sentence with checksum `*6B`: chk_err pulses and outputs keep their previous values.
- `$GPGGA,...*hh` with a valid checksum produces no pulse and no output change.
- A sentence truncated by LF before `*`, then a full valid sentence: only the second one commits.
- rst_n asserted low mid-field: outputs return to PAD and length 0 immediately, and the next valid sentence commits normally.
- Build with FIELD_IDX {7,7,2,2} and lowercase checksum `*6a`: the duplicate slots capture identical data and frame_valid pulses.
